dec_stage: RTL

- Registered, pipelined RV32I instruction-decode stage with a valid/ready handshake on both sides and a 2-entry skid buffer, so it sustains one instruction per cycle.
- Sits between the fetch unit and the execute/LSU stage.
- Generalises the combinational decoder:
  - parametrised datapath width;
  - adds AUIPC, JAL, BRANCH and illegal-instruction detection;
  - adds flush;
  - replaces simulation-stop on ECALL/EBREAK with a sticky hardware halt.

---
 rtl/dec_stage_if.sv | 40 ++++
 rtl/dec_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_stage_if.sv
// dec_stage_if: handshake bundle between fetch, the decode stage and the
// execute/LSU stage.
//   in_valid/in_ready/inst          fetch -> decode channel
//   out_valid/out_ready + fields    decode -> execute channel
// modport slave is the decode stage's view; modport master is the view of
// whoever drives fetch and consumes the decoded bundle.
interface dec_stage_if #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5,
  parameter int STRB_W   = XLEN/8
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         inst;
  logic                out_valid;
  logic                out_ready;
  logic [REG_ID_W-1:0] rd;
  logic [REG_ID_W-1:0] rs1;
  logic [REG_ID_W-1:0] rs2;
  logic [XLEN-1:0]     imm;
  logic [3:0]          alu_op;
  logic [2:0]          funct3;
  logic [STRB_W-1:0]   mem_wbmask;
  logic [1:0]          mem_size;
  logic                is_mem_sign;
  logic [3:0]          inst_type;
  logic                illegal;

  modport master (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid, rd, rs1, rs2, imm, alu_op, funct3,
           mem_wbmask, mem_size, is_mem_sign, inst_type, illegal
  );

  modport slave (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid, rd, rs1, rs2, imm, alu_op, funct3,
           mem_wbmask, mem_size, is_mem_sign, inst_type, illegal
  );
endinterface

// File: rtl/dec_stage.sv
// dec_stage: registered RV32I decode stage with a one-entry skid buffer behind
// the output register, so fetch can stream one instruction per cycle while
// in_ready stays a pure flop output.
//   clock  rising-edge clock
//   reset  asynchronous, active-high
//   flush  synchronous drop of everything buffered (halt is kept)
//   io     dec_stage_if.slave: fetch channel in, decoded bundle out
//   halt   sticky, set once an ECALL/EBREAK bundle has been handed downstream
module dec_stage #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5,
  parameter int STRB_W   = XLEN/8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  dec_stage_if.slave io,
  output logic       halt
);
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam bit         IS64       = (XLEN == 64);

  // is_env travels with the bundle so halt can be raised when it leaves.
  typedef struct packed {
    logic [REG_ID_W-1:0] rd;
    logic [REG_ID_W-1:0] rs1;
    logic [REG_ID_W-1:0] rs2;
    logic [XLEN-1:0]     imm;
    logic [3:0]          alu_op;
    logic [2:0]          funct3;
    logic [STRB_W-1:0]   mem_wbmask;
    logic [1:0]          mem_size;
    logic                is_mem_sign;
    logic [3:0]          inst_type;
    logic                illegal;
    logic                is_env;
  } bundle_t;

  bundle_t     dec;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm32;
  logic        ill;

  always_comb begin
    opcode          = io.inst[6:0];
    f3              = io.inst[14:12];
    imm32           = '0;
    ill             = 1'b0;
    dec             = '0;
    dec.rd          = REG_ID_W'(io.inst[11:7]);
    dec.rs1         = REG_ID_W'(io.inst[19:15]);
    dec.rs2         = REG_ID_W'(io.inst[24:20]);
    dec.funct3      = f3;
    dec.is_mem_sign = ~f3[2];
    case (opcode)
      OPC_OP_IMM: begin
        imm32         = {{20{io.inst[31]}}, io.inst[31:20]};
        dec.alu_op    = {io.inst[30] & (f3 == 3'b101), f3};
        dec.inst_type = 4'd1;
      end
      OPC_OP: begin
        dec.alu_op    = {io.inst[30], f3};
        dec.inst_type = 4'd2;
      end
      OPC_STORE: begin
        imm32         = {{20{io.inst[31]}}, io.inst[31:25], io.inst[11:7]};
        dec.mem_size  = f3[1:0];
        dec.inst_type = 4'd3;
        ill           = f3[2] | ((f3[1:0] == 2'b11) & !IS64);
        case (f3[1:0])
          2'b00:   dec.mem_wbmask = STRB_W'(8'h01);
          2'b01:   dec.mem_wbmask = STRB_W'(8'h03);
          2'b10:   dec.mem_wbmask = STRB_W'(8'h0F);
          default: dec.mem_wbmask = STRB_W'(8'hFF);
        endcase
      end
      OPC_LUI: begin
        imm32         = {io.inst[31:12], 12'b0};
        dec.inst_type = 4'd4;
      end
      OPC_JALR: begin
        imm32         = {{20{io.inst[31]}}, io.inst[31:20]};
        dec.inst_type = 4'd5;
      end
      OPC_AUIPC: begin
        imm32         = {io.inst[31:12], 12'b0};
        dec.inst_type = 4'd6;
      end
      OPC_JAL: begin
        imm32         = {{12{io.inst[31]}}, io.inst[19:12], io.inst[20],
                         io.inst[30:21], 1'b0};
        dec.inst_type = 4'd7;
      end
      OPC_LOAD: begin
        imm32         = {{20{io.inst[31]}}, io.inst[31:20]};
        dec.mem_size  = f3[1:0];
        dec.inst_type = {2'b10, f3[1:0]};
        // LD/LWU only exist on the 64-bit datapath
        ill           = (f3 == 3'b111) |
                        (!IS64 & ((f3 == 3'b011) | (f3 == 3'b110)));
      end
      OPC_BRANCH: begin
        imm32         = {{20{io.inst[31]}}, io.inst[7], io.inst[30:25],
                         io.inst[11:8], 1'b0};
        dec.inst_type = 4'd12;
        ill           = (f3[2:1] == 2'b01);
      end
      OPC_SYSTEM: begin
        imm32         = {{20{io.inst[31]}}, io.inst[31:20]};
        dec.inst_type = 4'd13;
        dec.is_env    = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    if (ill) begin
      dec.illegal    = 1'b1;
      dec.inst_type  = 4'd0;
      dec.mem_wbmask = '0;
    end
  end

  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_full_q, skid_full_d;
  logic    halt_pending_q, halt_pending_d;
  logic    halt_q, halt_d;
  logic    in_ready_q, in_ready_d;
  logic    accept, out_fire;

  always_comb begin
    accept         = io.in_valid & in_ready_q;
    out_fire       = out_valid_q & io.out_ready;
    out_valid_d    = out_valid_q;
    out_d          = out_q;
    skid_full_d    = skid_full_q;
    skid_d         = skid_q;
    halt_pending_d = halt_pending_q;
    halt_d         = halt_q;
    if (flush) begin
      out_valid_d    = 1'b0;
      skid_full_d    = 1'b0;
      halt_pending_d = 1'b0;
    end else begin
      if (out_fire && out_q.is_env) halt_d = 1'b1;
      if (accept && dec.is_env) halt_pending_d = 1'b1;
      if (out_fire || !out_valid_q) begin
        // in_ready is low whenever the skid is full, so accept and a skid
        // refill never coincide here.
        if (skid_full_q) begin
          out_d       = skid_q;
          out_valid_d = 1'b1;
          skid_full_d = 1'b0;
        end else if (accept) begin
          out_d       = dec;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d      = dec;
        skid_full_d = 1'b1;
      end
    end
    in_ready_d = !skid_full_d && !halt_pending_d && !halt_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q          <= '0;
      skid_q         <= '0;
      out_valid_q    <= 1'b0;
      skid_full_q    <= 1'b0;
      halt_pending_q <= 1'b0;
      halt_q         <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      out_q          <= out_d;
      skid_q         <= skid_d;
      out_valid_q    <= out_valid_d;
      skid_full_q    <= skid_full_d;
      halt_pending_q <= halt_pending_d;
      halt_q         <= halt_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = out_valid_q;
  assign io.rd          = out_q.rd;
  assign io.rs1         = out_q.rs1;
  assign io.rs2         = out_q.rs2;
  assign io.imm         = out_q.imm;
  assign io.alu_op      = out_q.alu_op;
  assign io.funct3      = out_q.funct3;
  assign io.mem_wbmask  = out_q.mem_wbmask;
  assign io.mem_size    = out_q.mem_size;
  assign io.is_mem_sign = out_q.is_mem_sign;
  assign io.inst_type   = out_q.inst_type;
  assign io.illegal     = out_q.illegal;
  assign halt           = halt_q;
endmodule
